l2_arbiter: RTL
===============

Name: l2_arbiter

Overview:
- Shares the single L2 port between I-cache misses (port A side) and D-cache misses (port B side) in the pipelined LC-3b.
- Grants one whole line transaction at a time and steers the L2 response back to the winner only.
- Uses round-robin on simultaneous requests.
- Exposes a saturating contention counter for the performance-counter mux.

Parameters:
- LINE_WIDTH, 128, cache line width in bits.
- ADDR_WIDTH, 16, line address width.
- CNT_WIDTH, 16, contention counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_read  in  1  I-cache line read request; held until i_resp.
- i_address  in  ADDR_WIDTH  I-cache line address.
- i_rdata  out  LINE_WIDTH  line data to I-cache.
- i_resp  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line read request; held until d_resp.
- d_write  in  1  D-cache writeback request; held until d_resp.
- d_address  in  ADDR_WIDTH  D-cache line address.
- d_wdata  in  LINE_WIDTH  writeback line data.
- d_rdata  out  LINE_WIDTH  line data to D-cache.
- d_resp  out  1  one-cycle completion pulse to D-cache.
- l2_read  out  1  read request to L2.
- l2_write  out  1  write request to L2.
- l2_address  out  ADDR_WIDTH  address to L2.
- l2_wdata  out  LINE_WIDTH  write data to L2.
- l2_rdata  in  LINE_WIDTH  L2 read data.
- l2_resp  in  1  L2 completion; high exactly one cycle per transaction.
- counters_reset  in  1  synchronous clear of contention_count.
- contention_count  out  CNT_WIDTH  cycles in IDLE with both sides requesting, saturating.

Behaviour:
- States: IDLE, GRANT_I, GRANT_D, RELEASE. Encoding lives in the package.
- Reset (rst=1 at an edge):
  - state <= IDLE, last_served <= I, contention_count <= 0.
  - All l2_* outputs and i_resp/d_resp are 0 while in IDLE.
  - Reset mid-transaction abandons the grant.
  - An l2_resp arriving in IDLE or RELEASE is ignored; no resp is forwarded.
- Request terms: i_req = i_read; d_req = d_read | d_write.
  - d_read & d_write together is illegal; d_write wins (l2_read = d_read & ~d_write in GRANT_D).
- IDLE transitions:
  - Only i_req -> GRANT_I.
  - Only d_req -> GRANT_D.
  - Both -> grant the side not equal to last_served. After reset, D wins the first tie.
  - Neither -> stay.
  - Decision is registered, so the grant takes effect the cycle after the request is seen (1-cycle arbitration latency).
- GRANT_I:
  - l2_read=1, l2_write=0, l2_address=i_address, l2_wdata=0.
  - On l2_resp: i_resp=1 the same cycle (combinational), last_served <= I, next state RELEASE.
- GRANT_D:
  - l2_read=d_read&~d_write, l2_write=d_write, l2_address=d_address, l2_wdata=d_wdata.
  - On l2_resp: d_resp=1 the same cycle, last_served <= D, next state RELEASE.
- RELEASE:
  - One dead cycle with all l2_* = 0, so the requester can drop or renew its request and L2 sees a request edge.
  - Always returns to IDLE.
- Response gating:
  - i_rdata and d_rdata are both driven with l2_rdata unconditionally.
  - Only the granted side's resp may pulse. The ungranted resp is never 1.
- Request withdrawal: a requester dropping its request mid-grant is a protocol violation. The arbiter stays in the grant state until l2_resp.
- Minimum per-transaction occupancy: 1 (arbitration) + L2 latency + 1 (release) cycles.
- contention_count:
  - Increments by 1 on each cycle in IDLE with i_req & d_req.
  - Saturates at all-ones.
  - counters_reset or rst clears it to 0 and has priority over increment.

Decomposition:
- Shared package lc3b_types gains:
  - arb_state_t enum {IDLE, GRANT_I, GRANT_D, RELEASE}
  - lc3b_line typedef (logic [127:0])
  - arb_side_t enum {SIDE_I, SIDE_D}
- One sub-module: sat_counter (width-parameterised, synchronous clear, saturating increment), reused for contention_count.
- FSM, output steering and tie-break remain in l2_arbiter.

Test Plan:
- I-read only: i_read=1, i_address=16'h1230. L2 responds after 3 cycles with l2_rdata=128'hA5…A5.
  -> l2_read asserted from cycle 1 with l2_address=16'h1230; i_resp pulses once with i_rdata=A5…A5; d_resp stays 0; RELEASE cycle has l2_read=0.
- Simultaneous after reset: i_read and d_read asserted together.
  -> D granted first (l2_address=d_address), then I after RELEASE+IDLE.
  -> Next tie with last_served=I grants D again; a tie following an I-last grant chooses D, and one following a D-last grant chooses I.
- D writeback: d_write=1, d_address=16'h0040, d_wdata=128'hDEAD…BEEF.
  -> l2_write=1, l2_read=0, l2_wdata matches; d_resp pulses on l2_resp.
- d_read&d_write both high -> l2_write=1, l2_read=0.
- Reset mid-grant: rst=1 during GRANT_I, then l2_resp arrives next cycle.
  -> state IDLE, all outputs 0, i_resp never pulses, contention_count=0.
- Contention counter: hold both requests in IDLE repeatedly with CNT_WIDTH=4 over 20 contended cycles.
  -> count saturates at 4'hF.
  -> counters_reset=1 -> 0 next cycle, even if contention is present that cycle.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b type definitions for the L2 arbiter slice
package lc3b_types;
  typedef logic [127:0] lc3b_line;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} arb_state_t;
  typedef enum logic {SIDE_I, SIDE_D} arb_side_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk)
    count <= clr ? '0 : (inc && !(&count)) ? count + WIDTH'(1) : count;
endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin arbiter sharing one L2 port between I-cache and D-cache misses
module l2_arbiter
  import lc3b_types::*;
#(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp,
  input  logic                  counters_reset,
  output logic [CNT_WIDTH-1:0]  contention_count
);
  arb_state_t state, next_state;
  arb_side_t  last_served;
  logic       i_req, d_req;
  assign i_req = i_read;
  assign d_req = d_read | d_write;
  always_ff @(posedge clk)
    if (rst) begin
      state       <= IDLE;
      last_served <= SIDE_I;
    end else begin
      state <= next_state;
      if (l2_resp && state == GRANT_I) last_served <= SIDE_I;
      else if (l2_resp && state == GRANT_D) last_served <= SIDE_D;
    end
  // On a tie the side that was not served last wins
  always_comb
    case (state)
      IDLE:             next_state = (i_req && d_req) ? (last_served == SIDE_I ? GRANT_D : GRANT_I) :
                                     i_req ? GRANT_I : d_req ? GRANT_D : IDLE;
      GRANT_I, GRANT_D: next_state = l2_resp ? RELEASE : state;
      default:          next_state = IDLE;
    endcase
  always_comb begin
    l2_read    = (state == GRANT_I) || (state == GRANT_D && d_read && !d_write);
    l2_write   = state == GRANT_D && d_write;
    l2_address = state == GRANT_I ? i_address : state == GRANT_D ? d_address : '0;
    l2_wdata   = state == GRANT_D ? d_wdata : '0;
    i_resp     = state == GRANT_I && l2_resp;
    d_resp     = state == GRANT_D && l2_resp;
  end
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;
  sat_counter #(.WIDTH(CNT_WIDTH)) u_contention (
    .clk  (clk),
    .clr  (rst || counters_reset),
    .inc  (state == IDLE && i_req && d_req),
    .count(contention_count)
  );
endmodule
